// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART definitions: receiver/transmitter state
//                encoding, oversampling constants and default frame shape.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Frame-level states; PARITY is only visited when parity is built in
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int OVERSAMPLE      = 16;  // s_tick pulses per bit period
  localparam int MID_START       = 7;   // tick index of the start-bit midpoint
  localparam int DBIT_DEFAULT    = 8;
  localparam int SB_TICK_DEFAULT = 16;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sync2
//  Description : Two-flop synchronizer for an asynchronous level input.
//                Resets to 1 so an idle-high serial line never looks like a
//                start bit on the way out of reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic r_meta;

  // Two back-to-back flops; only q is consumed by downstream logic
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_meta <= 1'b1;
      q      <= 1'b1;
    end else begin
      r_meta <= d;
      q      <= r_meta;
    end
  end

endmodule : uart_sync2
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 16x-oversampled UART receiver. Samples each bit at mid-bit,
//                assembles DBIT data bits LSB first and presents the word
//                with a one-cycle rx_done_tick; a low stop bit yields a
//                one-cycle frame_err instead.
//                Optional parity: define UART_RX_PARITY_EN to add a parity
//                bit after the data (parity_odd input, parity_err output).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEFAULT,
  parameter int SB_TICK = SB_TICK_DEFAULT
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            rx,
  input  logic            s_tick,
`ifdef UART_RX_PARITY_EN
  input  logic            parity_odd,
  output logic            parity_err,
`endif
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err
);

  // Tick counter needs a fifth bit once the stop phase exceeds one bit
  localparam int SW = (SB_TICK > OVERSAMPLE) ? 5 : 4;

  localparam logic [SW-1:0] C_S_MID  = SW'(MID_START);
  localparam logic [SW-1:0] C_S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] C_S_STOP = SW'(SB_TICK - 1);
  localparam logic [2:0]    C_N_LAST = 3'(DBIT - 1);

  uart_state_t     r_state;
  logic [SW-1:0]   r_s;
  logic [2:0]      r_n;
  logic [DBIT-1:0] r_sreg;
  logic            w_rx_s;
`ifdef UART_RX_PARITY_EN
  logic            r_par_bit;
`endif

  uart_sync2 u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx),
    .q       (w_rx_s)
  );

  // Frame FSM: counters advance only on s_tick; strobes are registered pulses
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_s          <= '0;
      r_n          <= '0;
      r_sreg       <= '0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit    <= 1'b0;
      parity_err   <= 1'b0;
`endif
    end else begin
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err   <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          // A tick coinciding with the falling edge is deliberately ignored
          if (!w_rx_s) begin
            r_state <= START;
            r_s     <= '0;
          end
        end
        START: begin
          if (s_tick) begin
            if (r_s == C_S_MID) begin
              if (!w_rx_s) begin
                r_state <= DATA;
                r_s     <= '0;
                r_n     <= '0;
              end else begin
                r_state <= IDLE;  // false start: line back high at mid-bit
              end
            end else begin
              r_s <= r_s + SW'(1);
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (r_s == C_S_LAST) begin
              r_s    <= '0;
              r_sreg <= {w_rx_s, r_sreg[DBIT-1:1]};
              if (r_n == C_N_LAST) begin
`ifdef UART_RX_PARITY_EN
                r_state <= PARITY;
`else
                r_state <= STOP;
`endif
              end else begin
                r_n <= r_n + 3'd1;
              end
            end else begin
              r_s <= r_s + SW'(1);
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (s_tick) begin
            if (r_s == C_S_LAST) begin
              r_s       <= '0;
              r_par_bit <= w_rx_s;
              r_state   <= STOP;
            end else begin
              r_s <= r_s + SW'(1);
            end
          end
        end
`endif
        STOP: begin
          if (s_tick) begin
            if (r_s == C_S_STOP) begin
              // Leaving at mid stop bit lets an immediate next start be seen
              r_state <= IDLE;
              if (w_rx_s) begin
                dout         <= r_sreg;
                rx_done_tick <= 1'b1;
`ifdef UART_RX_PARITY_EN
                parity_err   <= ((^r_sreg) ^ parity_odd) != r_par_bit;
`endif
              end else begin
                frame_err <= 1'b1;
              end
            end else begin
              r_s <= r_s + SW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Directed self-checking bench for uart_rx (8 data bits,
//                1 stop bit, tick every 27 clk, 432 clk per bit).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int BIT_CLK  = 432;
`ifdef UART_RX_PARITY_EN
  localparam int LAT_TICKS = 168;
`else
  localparam int LAT_TICKS = 152;
`endif

  logic       clk      = 1'b0;
  logic       reset_n  = 1'b0;
  logic       rx       = 1'b1;
  logic       s_tick   = 1'b0;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_odd = 1'b0;
  logic       parity_err;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  int cyc           = 0;
  int tick_cnt      = 0;
  int done_cnt      = 0;
  int ferr_cnt      = 0;
  int perr_cnt      = 0;
  int perr_alone    = 0;
  int last_done_cyc = 0;
  int start_cyc     = 0;
  logic [7:0] got_q[$];

  uart_rx dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx           (rx),
    .s_tick       (s_tick),
`ifdef UART_RX_PARITY_EN
    .parity_odd   (parity_odd),
    .parity_err   (parity_err),
`endif
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  // Baud tick: one pulse every 27 clocks
  always @(negedge clk) begin
    if (tick_cnt == 26) begin
      tick_cnt = 0;
      s_tick   = 1'b1;
    end else begin
      tick_cnt = tick_cnt + 1;
      s_tick   = 1'b0;
    end
  end

  // Strobe monitor, sampled mid-cycle
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rx_done_tick === 1'b1) begin
      done_cnt      = done_cnt + 1;
      last_done_cyc = cyc;
      got_q.push_back(dout);
    end
    if (frame_err === 1'b1) ferr_cnt = ferr_cnt + 1;
`ifdef UART_RX_PARITY_EN
    if (parity_err === 1'b1) begin
      perr_cnt = perr_cnt + 1;
      if (rx_done_tick !== 1'b1) perr_alone = perr_alone + 1;
    end
`endif
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_counts();
    done_cnt   = 0;
    ferr_cnt   = 0;
    perr_cnt   = 0;
    perr_alone = 0;
    got_q.delete();
  endtask

  // One frame; rst_bit pulses reset mid data bit, par<0 sends correct parity
  task automatic send_frame(input logic [7:0] d, input int rst_bit,
                            input bit stop_low, input int par);
    @(negedge clk);
    rx        = 1'b0;
    start_cyc = cyc;
    hold(BIT_CLK);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      if (i == rst_bit) begin
        hold(216);
        reset_n = 1'b0;
        hold(1);
        reset_n = 1'b1;
        hold(BIT_CLK - 217);
      end else begin
        hold(BIT_CLK);
      end
    end
`ifdef UART_RX_PARITY_EN
    rx = (par < 0) ? ^d : par[0];
    hold(BIT_CLK);
`else
    if (par > 99) hold(1);
`endif
    if (stop_low) begin
      rx = 1'b0;
      hold(324);
      rx = 1'b1;
      hold(BIT_CLK - 324);
    end else begin
      rx = 1'b1;
      hold(BIT_CLK);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    hold(5);
    n_checks++;
    if (dout !== 8'h00) begin
      n_fails++; $display("FAIL reset_dout: got %h expected 00", dout);
    end
    n_checks++;
    if (rx_done_tick !== 1'b0) begin
      n_fails++; $display("FAIL reset_done: got %b expected 0", rx_done_tick);
    end
    n_checks++;
    if (frame_err !== 1'b0) begin
      n_fails++; $display("FAIL reset_ferr: got %b expected 0", frame_err);
    end
    reset_n = 1'b1;
    hold(BIT_CLK);
  endtask

  task automatic test_basic();
    int lat;
    clear_counts();
    send_frame(8'hA5, -1, 1'b0, -1);
    hold(BIT_CLK);
    n_checks++;
    if (done_cnt != 1) begin
      n_fails++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt);
    end
    n_checks++;
    if (got_q.size() < 1 || got_q[0] !== 8'hA5) begin
      n_fails++; $display("FAIL basic_data: got %h expected a5",
                          (got_q.size() > 0) ? got_q[0] : 8'hxx);
    end
    n_checks++;
    if (dout !== 8'hA5) begin
      n_fails++; $display("FAIL basic_dout_hold: got %h expected a5", dout);
    end
    n_checks++;
    if (ferr_cnt != 0) begin
      n_fails++; $display("FAIL basic_ferr: got %0d expected 0", ferr_cnt);
    end
    lat = last_done_cyc - start_cyc;
    n_checks++;
    if (lat < LAT_TICKS * 27 - 40 || lat > LAT_TICKS * 27 + 20) begin
      n_fails++; $display("FAIL basic_latency: got %0d expected about %0d",
                          lat, LAT_TICKS * 27);
    end
  endtask

  task automatic test_glitch();
    clear_counts();
    @(negedge clk);
    rx = 1'b0;
    hold(81);
    rx = 1'b1;
    hold(2 * BIT_CLK);
    n_checks++;
    if (done_cnt != 0) begin
      n_fails++; $display("FAIL glitch_done: got %0d expected 0", done_cnt);
    end
    n_checks++;
    if (ferr_cnt != 0) begin
      n_fails++; $display("FAIL glitch_ferr: got %0d expected 0", ferr_cnt);
    end
    n_checks++;
    if (dout !== 8'hA5) begin
      n_fails++; $display("FAIL glitch_dout: got %h expected a5", dout);
    end
  endtask

  task automatic test_frame_err();
    clear_counts();
    send_frame(8'h3C, -1, 1'b1, -1);
    hold(2 * BIT_CLK);
    n_checks++;
    if (ferr_cnt != 1) begin
      n_fails++; $display("FAIL ferr_count: got %0d expected 1", ferr_cnt);
    end
    n_checks++;
    if (done_cnt != 0) begin
      n_fails++; $display("FAIL ferr_done: got %0d expected 0", done_cnt);
    end
    n_checks++;
    if (dout !== 8'hA5) begin
      n_fails++; $display("FAIL ferr_dout: got %h expected a5", dout);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [3];
    exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'h55;
    clear_counts();
    for (int k = 0; k < 3; k++) send_frame(exp[k], -1, 1'b0, -1);
    hold(BIT_CLK);
    n_checks++;
    if (done_cnt != 3) begin
      n_fails++; $display("FAIL b2b_count: got %0d expected 3", done_cnt);
    end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (got_q.size() <= k || got_q[k] !== exp[k]) begin
        n_fails++; $display("FAIL b2b_data%0d: got %h expected %h", k,
                            (got_q.size() > k) ? got_q[k] : 8'hxx, exp[k]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_counts();
    send_frame(8'hF7, 4, 1'b0, -1);
    hold(BIT_CLK);
    n_checks++;
    if (done_cnt != 0 || ferr_cnt != 0) begin
      n_fails++; $display("FAIL abort_strobe: got done=%0d ferr=%0d expected 0/0",
                          done_cnt, ferr_cnt);
    end
    n_checks++;
    if (dout !== 8'h00) begin
      n_fails++; $display("FAIL abort_dout: got %h expected 00", dout);
    end
    send_frame(8'h81, -1, 1'b0, -1);
    hold(BIT_CLK);
    n_checks++;
    if (done_cnt != 1) begin
      n_fails++; $display("FAIL after_abort_count: got %0d expected 1", done_cnt);
    end
    n_checks++;
    if (dout !== 8'h81) begin
      n_fails++; $display("FAIL after_abort_data: got %h expected 81", dout);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    clear_counts();
    send_frame(8'h07, -1, 1'b0, 1);
    hold(BIT_CLK);
    n_checks++;
    if (done_cnt != 1 || perr_cnt != 0) begin
      n_fails++; $display("FAIL parity_good: got done=%0d perr=%0d expected 1/0",
                          done_cnt, perr_cnt);
    end
    clear_counts();
    send_frame(8'h07, -1, 1'b0, 0);
    hold(BIT_CLK);
    n_checks++;
    if (done_cnt != 1 || perr_cnt != 1) begin
      n_fails++; $display("FAIL parity_bad: got done=%0d perr=%0d expected 1/1",
                          done_cnt, perr_cnt);
    end
    n_checks++;
    if (perr_alone != 0) begin
      n_fails++; $display("FAIL parity_align: got %0d lone pulses expected 0",
                          perr_alone);
    end
    n_checks++;
    if (dout !== 8'h07) begin
      n_fails++; $display("FAIL parity_dout: got %h expected 07", dout);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule : tb_uart_rx
`default_nettype wire
